// File: rtl/glb_core_bank_arbiter_if.sv
// Bundle of the processor/stream request ports, the bank port and the
// read-return ports shared by the GLB core bank arbiter and its requesters.
interface glb_core_bank_arbiter_if #(
  parameter int BANK_ADDR_WIDTH = 17,
  parameter int BANK_DATA_WIDTH = 64,
  parameter int BANK_STRB_WIDTH = 8
) ();
  logic                       cfg_strm_priority;

  logic                       proc_req_valid;
  logic                       proc_req_wr;
  logic [BANK_ADDR_WIDTH-1:0] proc_req_addr;
  logic [BANK_DATA_WIDTH-1:0] proc_req_wdata;
  logic [BANK_STRB_WIDTH-1:0] proc_req_wstrb;
  logic                       proc_req_ready;

  logic                       strm_req_valid;
  logic                       strm_req_wr;
  logic [BANK_ADDR_WIDTH-1:0] strm_req_addr;
  logic [BANK_DATA_WIDTH-1:0] strm_req_wdata;
  logic [BANK_STRB_WIDTH-1:0] strm_req_wstrb;
  logic                       strm_req_ready;

  logic                       bank_en;
  logic                       bank_wr;
  logic [BANK_ADDR_WIDTH-1:0] bank_addr;
  logic [BANK_DATA_WIDTH-1:0] bank_wdata;
  logic [BANK_STRB_WIDTH-1:0] bank_wstrb;
  logic [BANK_DATA_WIDTH-1:0] bank_rdata;

  logic                       proc_rd_valid;
  logic [BANK_DATA_WIDTH-1:0] proc_rd_data;
  logic                       strm_rd_valid;
  logic [BANK_DATA_WIDTH-1:0] strm_rd_data;

  // requester/bank side (drives requests and read data)
  modport master (
    output cfg_strm_priority,
    output proc_req_valid, proc_req_wr, proc_req_addr, proc_req_wdata, proc_req_wstrb,
    input  proc_req_ready,
    output strm_req_valid, strm_req_wr, strm_req_addr, strm_req_wdata, strm_req_wstrb,
    input  strm_req_ready,
    input  bank_en, bank_wr, bank_addr, bank_wdata, bank_wstrb,
    output bank_rdata,
    input  proc_rd_valid, proc_rd_data, strm_rd_valid, strm_rd_data
  );

  // arbiter side
  modport slave (
    input  cfg_strm_priority,
    input  proc_req_valid, proc_req_wr, proc_req_addr, proc_req_wdata, proc_req_wstrb,
    output proc_req_ready,
    input  strm_req_valid, strm_req_wr, strm_req_addr, strm_req_wdata, strm_req_wstrb,
    output strm_req_ready,
    output bank_en, bank_wr, bank_addr, bank_wdata, bank_wstrb,
    input  bank_rdata,
    output proc_rd_valid, proc_rd_data, strm_rd_valid, strm_rd_data
  );
endinterface

// File: rtl/glb_core_bank_arbiter.sv
// GLB core bank arbiter: one bank access per cycle shared between the
// processor path and the stream path, with a read-tag pipeline that routes
// returning bank data to the requester that issued the read.
//
// Arbitration state (no other FSM):
//   state      | meaning
//   GRANT_PROC | last accepted request came from the processor path
//   GRANT_STRM | last accepted request came from the stream path (reset)
module glb_core_bank_arbiter #(
  parameter int BANK_ADDR_WIDTH = 17,
  parameter int BANK_DATA_WIDTH = 64,
  parameter int BANK_STRB_WIDTH = 8,
  parameter int BANK_RD_LATENCY = 2
) (
  input logic                   clk,
  input logic                   reset,
  glb_core_bank_arbiter_if.slave bus
);

  typedef enum logic {
    GRANT_PROC = 1'b0,
    GRANT_STRM = 1'b1
  } grant_e;

  grant_e                     last_grant;
  logic                       proc_win;
  logic                       strm_win;
  logic                       accept;

  logic                       bank_en_q;
  logic                       bank_wr_q;
  logic [BANK_ADDR_WIDTH-1:0] bank_addr_q;
  logic [BANK_DATA_WIDTH-1:0] bank_wdata_q;
  logic [BANK_STRB_WIDTH-1:0] bank_wstrb_q;
  logic                       issue_is_proc_q;

  logic [BANK_RD_LATENCY-1:0] tag_valid;
  logic [BANK_RD_LATENCY-1:0] tag_proc;
  logic                       tag_in_valid;

  // Grant decision; readies are held low while reset is asserted so that
  // no handshake completes against a block that is being cleared.
  always_comb begin
    proc_win = 1'b0;
    strm_win = 1'b0;
    if (!reset) begin
      if (bus.proc_req_valid && bus.strm_req_valid) begin
        if (bus.cfg_strm_priority) begin
          strm_win = 1'b1;
        end else if (last_grant == GRANT_STRM) begin
          proc_win = 1'b1;
        end else begin
          strm_win = 1'b1;
        end
      end else begin
        proc_win = bus.proc_req_valid;
        strm_win = bus.strm_req_valid;
      end
    end
  end

  assign accept             = proc_win | strm_win;
  assign bus.proc_req_ready = proc_win;
  assign bus.strm_req_ready = strm_win;

  // Register the winning request onto the bank; fields hold when idle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant      <= GRANT_STRM;
      bank_en_q       <= 1'b0;
      bank_wr_q       <= 1'b0;
      bank_addr_q     <= '0;
      bank_wdata_q    <= '0;
      bank_wstrb_q    <= '0;
      issue_is_proc_q <= 1'b0;
    end else begin
      bank_en_q <= accept;
      if (strm_win) begin
        last_grant      <= GRANT_STRM;
        bank_wr_q       <= bus.strm_req_wr;
        bank_addr_q     <= bus.strm_req_addr;
        bank_wdata_q    <= bus.strm_req_wdata;
        bank_wstrb_q    <= bus.strm_req_wstrb;
        issue_is_proc_q <= 1'b0;
      end else if (proc_win) begin
        last_grant      <= GRANT_PROC;
        bank_wr_q       <= bus.proc_req_wr;
        bank_addr_q     <= bus.proc_req_addr;
        bank_wdata_q    <= bus.proc_req_wdata;
        bank_wstrb_q    <= bus.proc_req_wstrb;
        issue_is_proc_q <= 1'b1;
      end
    end
  end

  assign bus.bank_en    = bank_en_q;
  assign bus.bank_wr    = bank_wr_q;
  assign bus.bank_addr  = bank_addr_q;
  assign bus.bank_wdata = bank_wdata_q;
  assign bus.bank_wstrb = bank_wstrb_q;

  // A read enters the tag pipe in the cycle it is on the bank, so the last
  // stage lines up with bank_rdata BANK_RD_LATENCY cycles later.
  assign tag_in_valid = bank_en_q & ~bank_wr_q;

  // Tag shift register tracking which requester owns each in-flight read.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tag_valid <= '0;
      tag_proc  <= '0;
    end else begin
      tag_valid[0] <= tag_in_valid;
      tag_proc[0]  <= issue_is_proc_q;
      for (int i = 1; i < BANK_RD_LATENCY; i++) begin
        tag_valid[i] <= tag_valid[i-1];
        tag_proc[i]  <= tag_proc[i-1];
      end
    end
  end

  assign bus.proc_rd_valid = tag_valid[BANK_RD_LATENCY-1] &  tag_proc[BANK_RD_LATENCY-1];
  assign bus.strm_rd_valid = tag_valid[BANK_RD_LATENCY-1] & ~tag_proc[BANK_RD_LATENCY-1];
  assign bus.proc_rd_data  = reset ? '0 : bus.bank_rdata;
  assign bus.strm_rd_data  = reset ? '0 : bus.bank_rdata;

endmodule

// File: tb/tb_glb_core_bank_arbiter.sv
// Self-checking bench for glb_core_bank_arbiter: a bank SRAM model answers
// reads with fixed latency, and a scoreboard predicts bank issues, grants and
// read returns independently from a reference memory.
module tb_glb_core_bank_arbiter;
  localparam int AW  = 17;
  localparam int DW  = 64;
  localparam int SW  = 8;
  localparam int LAT = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  glb_core_bank_arbiter_if #(.BANK_ADDR_WIDTH(AW), .BANK_DATA_WIDTH(DW), .BANK_STRB_WIDTH(SW)) bus ();

  glb_core_bank_arbiter #(
    .BANK_ADDR_WIDTH(AW), .BANK_DATA_WIDTH(DW), .BANK_STRB_WIDTH(SW), .BANK_RD_LATENCY(LAT)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  typedef struct {
    int            due;
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [SW-1:0] wstrb;
  } bank_exp_t;
  typedef struct {
    int            due;
    logic          is_proc;
    logic [DW-1:0] data;
  } rd_exp_t;
  typedef struct {
    int            due;
    logic [DW-1:0] data;
  } rd_sched_t;

  bank_exp_t bank_q[$];
  rd_exp_t   rd_q[$];
  rd_sched_t sched_q[$];
  logic [DW-1:0] bmem[int];
  logic [DW-1:0] rmem[int];
  logic          model_last_strm = 1'b1;
  logic          last_wr = 1'b0;
  logic [AW-1:0] last_addr = '0;
  logic [DW-1:0] last_wdata = '0;
  logic [SW-1:0] last_wstrb = '0;

  function automatic logic [DW-1:0] mem_init(input int a);
    return {32'h5A00_0000 ^ 32'(a), 32'(a) * 32'd7 + 32'h1234};
  endfunction

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] wd,
                                          input logic [SW-1:0] st);
    logic [DW-1:0] r;
    r = old;
    for (int b = 0; b < SW; b++) if (st[b]) r[b*8 +: 8] = wd[b*8 +: 8];
    return r;
  endfunction

  function automatic logic [DW-1:0] bread(input int a);
    return bmem.exists(a) ? bmem[a] : mem_init(a);
  endfunction

  function automatic logic [DW-1:0] rread(input int a);
    return rmem.exists(a) ? rmem[a] : mem_init(a);
  endfunction

  // Bank SRAM model: returns scheduled read data, random data otherwise.
  always @(posedge clk) begin
    cyc++;
    #1;
    while (sched_q.size() > 0 && sched_q[0].due < cyc) void'(sched_q.pop_front());
    if (sched_q.size() > 0 && sched_q[0].due == cyc) begin
      bus.bank_rdata = sched_q[0].data;
      void'(sched_q.pop_front());
    end else begin
      bus.bank_rdata = {$urandom, $urandom};
    end
  end

  // Per-cycle scoreboard: bank issue, read return, pass-through and grants.
  always @(negedge clk) begin
    bank_exp_t e;
    rd_exp_t   r;
    logic      exp_p, exp_s, win_p, win_s;
    logic [DW-1:0] got_d;
    if (reset) begin
      checks++;
      if (bus.bank_en !== 1'b0 || bus.proc_req_ready !== 1'b0 || bus.strm_req_ready !== 1'b0 ||
          bus.proc_rd_valid !== 1'b0 || bus.strm_rd_valid !== 1'b0) begin
        errors++;
        $display("FAIL reset_outputs: en=%b prdy=%b srdy=%b prv=%b srv=%b required all 0",
                 bus.bank_en, bus.proc_req_ready, bus.strm_req_ready, bus.proc_rd_valid, bus.strm_rd_valid);
      end
      bank_q.delete();
      rd_q.delete();
      sched_q.delete();
      model_last_strm = 1'b1;
      last_wr = 1'b0; last_addr = '0; last_wdata = '0; last_wstrb = '0;
    end else begin
      if (bank_q.size() > 0 && bank_q[0].due == cyc) begin
        e = bank_q.pop_front();
        checks++;
        if (bus.bank_en !== 1'b1 || bus.bank_wr !== e.wr || bus.bank_addr !== e.addr ||
            (e.wr && (bus.bank_wdata !== e.wdata || bus.bank_wstrb !== e.wstrb))) begin
          errors++;
          $display("FAIL bank_issue @%0d: en=%b wr=%b addr=%h wd=%h st=%h required en=1 wr=%b addr=%h wd=%h st=%h",
                   cyc, bus.bank_en, bus.bank_wr, bus.bank_addr, bus.bank_wdata, bus.bank_wstrb,
                   e.wr, e.addr, e.wdata, e.wstrb);
        end
        if (e.wr) bmem[int'(e.addr)] = merge(bread(int'(e.addr)), e.wdata, e.wstrb);
        else sched_q.push_back('{due: cyc + LAT, data: bread(int'(e.addr))});
        last_wr = e.wr; last_addr = e.addr; last_wdata = e.wdata; last_wstrb = e.wstrb;
      end else begin
        checks++;
        if (bus.bank_en !== 1'b0 || bus.bank_wr !== last_wr || bus.bank_addr !== last_addr ||
            bus.bank_wdata !== last_wdata || bus.bank_wstrb !== last_wstrb) begin
          errors++;
          $display("FAIL bank_idle_hold @%0d: en=%b wr=%b addr=%h required en=0 wr=%b addr=%h (fields held)",
                   cyc, bus.bank_en, bus.bank_wr, bus.bank_addr, last_wr, last_addr);
        end
      end

      exp_p = 1'b0; exp_s = 1'b0; r.data = '0;
      if (rd_q.size() > 0 && rd_q[0].due == cyc) begin
        r = rd_q.pop_front();
        exp_p = r.is_proc;
        exp_s = !r.is_proc;
      end
      checks++;
      if (bus.proc_rd_valid !== exp_p || bus.strm_rd_valid !== exp_s) begin
        errors++;
        $display("FAIL rd_valid @%0d: proc=%b strm=%b required proc=%b strm=%b",
                 cyc, bus.proc_rd_valid, bus.strm_rd_valid, exp_p, exp_s);
      end
      if (exp_p || exp_s) begin
        got_d = exp_p ? bus.proc_rd_data : bus.strm_rd_data;
        checks++;
        if (got_d !== r.data) begin
          errors++;
          $display("FAIL rd_data @%0d: got %h required %h", cyc, got_d, r.data);
        end
      end
      checks++;
      if (bus.proc_rd_data !== bus.bank_rdata || bus.strm_rd_data !== bus.bank_rdata) begin
        errors++;
        $display("FAIL rd_passthru @%0d: proc=%h strm=%h required %h",
                 cyc, bus.proc_rd_data, bus.strm_rd_data, bus.bank_rdata);
      end

      win_p = 1'b0; win_s = 1'b0;
      if (bus.proc_req_valid && bus.strm_req_valid) begin
        if (bus.cfg_strm_priority) win_s = 1'b1;
        else if (model_last_strm)  win_p = 1'b1;
        else                       win_s = 1'b1;
      end else begin
        win_p = bus.proc_req_valid;
        win_s = bus.strm_req_valid;
      end
      checks++;
      if (bus.proc_req_ready !== win_p || bus.strm_req_ready !== win_s) begin
        errors++;
        $display("FAIL grant @%0d: proc_rdy=%b strm_rdy=%b required proc_rdy=%b strm_rdy=%b",
                 cyc, bus.proc_req_ready, bus.strm_req_ready, win_p, win_s);
      end
      if (win_p) begin
        bank_q.push_back('{due: cyc + 1, wr: bus.proc_req_wr, addr: bus.proc_req_addr,
                           wdata: bus.proc_req_wdata, wstrb: bus.proc_req_wstrb});
        if (bus.proc_req_wr)
          rmem[int'(bus.proc_req_addr)] = merge(rread(int'(bus.proc_req_addr)), bus.proc_req_wdata, bus.proc_req_wstrb);
        else
          rd_q.push_back('{due: cyc + 1 + LAT, is_proc: 1'b1, data: rread(int'(bus.proc_req_addr))});
        model_last_strm = 1'b0;
      end else if (win_s) begin
        bank_q.push_back('{due: cyc + 1, wr: bus.strm_req_wr, addr: bus.strm_req_addr,
                           wdata: bus.strm_req_wdata, wstrb: bus.strm_req_wstrb});
        if (bus.strm_req_wr)
          rmem[int'(bus.strm_req_addr)] = merge(rread(int'(bus.strm_req_addr)), bus.strm_req_wdata, bus.strm_req_wstrb);
        else
          rd_q.push_back('{due: cyc + 1 + LAT, is_proc: 1'b0, data: rread(int'(bus.strm_req_addr))});
        model_last_strm = 1'b1;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_proc(input logic v, input logic wr, input logic [AW-1:0] a,
                          input logic [DW-1:0] wd, input logic [SW-1:0] st);
    bus.proc_req_valid = v; bus.proc_req_wr = wr; bus.proc_req_addr = a;
    bus.proc_req_wdata = wd; bus.proc_req_wstrb = st;
  endtask

  task automatic set_strm(input logic v, input logic wr, input logic [AW-1:0] a,
                          input logic [DW-1:0] wd, input logic [SW-1:0] st);
    bus.strm_req_valid = v; bus.strm_req_wr = wr; bus.strm_req_addr = a;
    bus.strm_req_wdata = wd; bus.strm_req_wstrb = st;
  endtask

  task automatic idle();
    set_proc(1'b0, 1'b0, '0, '0, '0);
    set_strm(1'b0, 1'b0, '0, '0, '0);
  endtask

  task automatic drain();
    idle();
    repeat (LAT + 3) step();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    set_proc(1'b1, 1'b0, 17'h10, '0, '0);
    set_strm(1'b1, 1'b0, 17'h20, '0, '0);
    repeat (3) step();
    @(negedge clk);
    checks++;
    if (bus.proc_req_ready !== 1'b0 || bus.strm_req_ready !== 1'b0 || bus.bank_en !== 1'b0 ||
        bus.bank_addr !== '0 || bus.bank_wr !== 1'b0) begin
      errors++;
      $display("FAIL test_reset: prdy=%b srdy=%b en=%b addr=%h wr=%b required all 0",
               bus.proc_req_ready, bus.strm_req_ready, bus.bank_en, bus.bank_addr, bus.bank_wr);
    end
    step();
    idle();
    reset = 1'b0;
    repeat (2) step();
  endtask

  task automatic test_conflict_rr();
    bus.cfg_strm_priority = 1'b0;
    set_proc(1'b1, 1'b0, 17'h100, '0, '0);
    set_strm(1'b1, 1'b0, 17'h200, '0, '0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++;
      if (bus.proc_req_ready !== (k % 2 == 0) || bus.strm_req_ready !== (k % 2 == 1)) begin
        errors++;
        $display("FAIL test_conflict_rr grant %0d: proc_rdy=%b strm_rdy=%b required proc_rdy=%b",
                 k, bus.proc_req_ready, bus.strm_req_ready, (k % 2 == 0));
      end
      if (k > 0) begin
        checks++;
        if (bus.bank_en !== 1'b1) begin
          errors++;
          $display("FAIL test_conflict_rr bank_en %0d: got %b required 1", k, bus.bank_en);
        end
      end
      step();
    end
    idle();
    @(negedge clk);
    checks++;
    if (bus.bank_en !== 1'b1) begin
      errors++;
      $display("FAIL test_conflict_rr last bank_en: got %b required 1", bus.bank_en);
    end
    step();
    @(negedge clk);
    checks++;
    if (bus.bank_en !== 1'b0) begin
      errors++;
      $display("FAIL test_conflict_rr bank_en after: got %b required 0", bus.bank_en);
    end
    drain();
  endtask

  task automatic test_single_read();
    set_proc(1'b1, 1'b0, 17'h40, '0, '0);
    step();
    idle();
    @(negedge clk);
    checks++;
    if (bus.bank_en !== 1'b1 || bus.bank_wr !== 1'b0 || bus.bank_addr !== 17'h40) begin
      errors++;
      $display("FAIL test_single_read issue: en=%b wr=%b addr=%h required en=1 wr=0 addr=00040",
               bus.bank_en, bus.bank_wr, bus.bank_addr);
    end
    step();
    @(negedge clk);
    checks++;
    if (bus.proc_rd_valid !== 1'b0) begin
      errors++;
      $display("FAIL test_single_read early: proc_rd_valid=%b required 0", bus.proc_rd_valid);
    end
    step();
    @(negedge clk);
    checks++;
    if (bus.proc_rd_valid !== 1'b1 || bus.strm_rd_valid !== 1'b0 ||
        bus.proc_rd_data !== 64'h0000_0000_DEAD_BEEF) begin
      errors++;
      $display("FAIL test_single_read return: prv=%b srv=%b data=%h required 1 0 00000000deadbeef",
               bus.proc_rd_valid, bus.strm_rd_valid, bus.proc_rd_data);
    end
    step();
    @(negedge clk);
    checks++;
    if (bus.proc_rd_valid !== 1'b0) begin
      errors++;
      $display("FAIL test_single_read late: proc_rd_valid=%b required 0", bus.proc_rd_valid);
    end
    drain();
  endtask

  task automatic test_strm_priority();
    bus.cfg_strm_priority = 1'b1;
    set_proc(1'b1, 1'b0, 17'h2F0, '0, '0);
    for (int k = 0; k < 3; k++) begin
      set_strm(1'b1, 1'b0, AW'(17'h300 + k * 8), '0, '0);
      @(negedge clk);
      checks++;
      if (bus.strm_req_ready !== 1'b1 || bus.proc_req_ready !== 1'b0) begin
        errors++;
        $display("FAIL test_strm_priority %0d: strm_rdy=%b proc_rdy=%b required 1 0",
                 k, bus.strm_req_ready, bus.proc_req_ready);
      end
      step();
    end
    set_strm(1'b0, 1'b0, '0, '0, '0);
    @(negedge clk);
    checks++;
    if (bus.proc_req_ready !== 1'b1) begin
      errors++;
      $display("FAIL test_strm_priority proc_after: proc_rdy=%b required 1", bus.proc_req_ready);
    end
    step();
    bus.cfg_strm_priority = 1'b0;
    drain();
  endtask

  task automatic test_interleaved();
    logic [DW-1:0] exp_p, exp_s;
    exp_p = rread(32'h500);
    exp_s = rread(32'h508);
    set_proc(1'b1, 1'b0, 17'h500, '0, '0);
    step();
    set_proc(1'b0, 1'b0, '0, '0, '0);
    set_strm(1'b1, 1'b0, 17'h508, '0, '0);
    step();
    idle();
    step();
    @(negedge clk);
    checks++;
    if (bus.proc_rd_valid !== 1'b1 || bus.strm_rd_valid !== 1'b0 || bus.proc_rd_data !== exp_p) begin
      errors++;
      $display("FAIL test_interleaved proc: prv=%b srv=%b data=%h required 1 0 %h",
               bus.proc_rd_valid, bus.strm_rd_valid, bus.proc_rd_data, exp_p);
    end
    step();
    @(negedge clk);
    checks++;
    if (bus.strm_rd_valid !== 1'b1 || bus.proc_rd_valid !== 1'b0 || bus.strm_rd_data !== exp_s) begin
      errors++;
      $display("FAIL test_interleaved strm: srv=%b prv=%b data=%h required 1 0 %h",
               bus.strm_rd_valid, bus.proc_rd_valid, bus.strm_rd_data, exp_s);
    end
    drain();
  endtask

  task automatic test_write_then_read();
    logic [DW-1:0] old, exp;
    old = mem_init(32'h80);
    exp = {old[DW-1:16], 16'h1122};
    set_proc(1'b1, 1'b1, 17'h80, 64'h0000_0000_0000_1122, 8'h03);
    step();
    set_proc(1'b0, 1'b0, '0, '0, '0);
    set_strm(1'b1, 1'b0, 17'h80, '0, '0);
    @(negedge clk);
    checks++;
    if (bus.bank_en !== 1'b1 || bus.bank_wr !== 1'b1 || bus.bank_addr !== 17'h80 || bus.bank_wstrb !== 8'h03) begin
      errors++;
      $display("FAIL test_write_then_read write: en=%b wr=%b addr=%h st=%h required 1 1 00080 03",
               bus.bank_en, bus.bank_wr, bus.bank_addr, bus.bank_wstrb);
    end
    step();
    idle();
    @(negedge clk);
    checks++;
    if (bus.bank_en !== 1'b1 || bus.bank_wr !== 1'b0 || bus.bank_addr !== 17'h80) begin
      errors++;
      $display("FAIL test_write_then_read read: en=%b wr=%b addr=%h required 1 0 00080",
               bus.bank_en, bus.bank_wr, bus.bank_addr);
    end
    repeat (LAT) step();
    @(negedge clk);
    checks++;
    if (bus.strm_rd_valid !== 1'b1 || bus.proc_rd_valid !== 1'b0 || bus.strm_rd_data !== exp) begin
      errors++;
      $display("FAIL test_write_then_read return: srv=%b prv=%b data=%h required 1 0 %h",
               bus.strm_rd_valid, bus.proc_rd_valid, bus.strm_rd_data, exp);
    end
    drain();
  endtask

  task automatic test_reset_mid();
    // make proc the last grant so a missed reset of last_grant shows up
    set_proc(1'b1, 1'b0, 17'h600, '0, '0);
    step();
    idle();
    reset = 1'b1;
    #1;
    checks++;
    if (bus.bank_en !== 1'b0 || bus.proc_req_ready !== 1'b0 || bus.strm_req_ready !== 1'b0 ||
        bus.proc_rd_valid !== 1'b0 || bus.strm_rd_valid !== 1'b0 || bus.bank_addr !== '0) begin
      errors++;
      $display("FAIL test_reset_mid immediate: en=%b addr=%h prdy=%b srdy=%b required all 0",
               bus.bank_en, bus.bank_addr, bus.proc_req_ready, bus.strm_req_ready);
    end
    step();
    step();
    reset = 1'b0;
    for (int k = 0; k < LAT + 2; k++) begin
      @(negedge clk);
      checks++;
      if (bus.proc_rd_valid !== 1'b0 || bus.strm_rd_valid !== 1'b0) begin
        errors++;
        $display("FAIL test_reset_mid stale %0d: prv=%b srv=%b required 0 0",
                 k, bus.proc_rd_valid, bus.strm_rd_valid);
      end
      step();
    end
    set_proc(1'b1, 1'b0, 17'h610, '0, '0);
    set_strm(1'b1, 1'b0, 17'h620, '0, '0);
    @(negedge clk);
    checks++;
    if (bus.proc_req_ready !== 1'b1 || bus.strm_req_ready !== 1'b0) begin
      errors++;
      $display("FAIL test_reset_mid first_conflict: proc_rdy=%b strm_rdy=%b required 1 0",
               bus.proc_req_ready, bus.strm_req_ready);
    end
    step();
    set_proc(1'b0, 1'b0, '0, '0, '0);
    step();
    drain();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    bus.cfg_strm_priority = 1'b0;
    bus.bank_rdata = '0;
    idle();
    bmem[32'h40] = 64'h0000_0000_DEAD_BEEF;
    rmem[32'h40] = 64'h0000_0000_DEAD_BEEF;
    test_reset();
    test_conflict_rr();
    test_single_read();
    test_strm_priority();
    test_interleaved();
    test_write_then_read();
    test_reset_mid();
    @(negedge clk);
    checks++;
    if (bank_q.size() != 0 || rd_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: bank_q=%0d rd_q=%0d required 0 0", bank_q.size(), rd_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
